// File: rtl/u8_fp16_converter_pkg.sv
// rtl/u8_fp16_converter_pkg.sv - fp16 field widths, packed fp16 type and packing helper
package u8_fp16_converter_pkg;

  localparam int EXP_WIDTH  = 5;
  localparam int FRAC_WIDTH = 10;
  localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EXP_MAX    = (1 << EXP_WIDTH) - 1;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [FRAC_WIDTH-1:0] frac;
  } fp16_t;

  function automatic fp16_t fp16_pack(
    input logic                  sign,
    input logic [EXP_WIDTH-1:0]  exp,
    input logic [FRAC_WIDTH-1:0] frac
  );
    fp16_t r;
    r.sign = sign;
    r.exp  = exp;
    r.frac = frac;
    return r;
  endfunction

endpackage

// File: rtl/u8_fp16_converter_if.sv
// rtl/u8_fp16_converter_if.sv - valid/ready bus between a u8 producer and an fp16 consumer
interface u8_fp16_converter_if;

  logic [7:0]  u8_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] fp16_o;
  logic        valid_o;
  logic        ready_i;

  modport slave (
    input  u8_i,
    input  valid_i,
    output ready_o,
    output fp16_o,
    output valid_o,
    input  ready_i
  );

  modport master (
    output u8_i,
    output valid_i,
    input  ready_o,
    input  fp16_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/u8_fp16_converter_lzc8.sv
// rtl/u8_fp16_converter_lzc8.sv - combinational 8-bit leading-zero counter, returns 8 for zero
module u8_fp16_converter_lzc8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count_o = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (data_i[i]) begin
        count_o = 4'(7 - i);
      end
    end
  end

endmodule

// File: rtl/u8_fp16_converter.sv
// rtl/u8_fp16_converter.sv - exact u8 fixed-point to fp16 converter, 2-stage valid/ready pipeline
module u8_fp16_converter
  import u8_fp16_converter_pkg::*;
#(
  parameter int LEAD_EXPONENT_UNBIASED = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  u8_fp16_converter_if.slave  bus
);

  localparam int LEAD_EXPONENT = LEAD_EXPONENT_UNBIASED + BIAS;

  generate
    if (LEAD_EXPONENT_UNBIASED < -7 || LEAD_EXPONENT_UNBIASED > 15) begin : g_param_check
      $error("u8_fp16_converter: LEAD_EXPONENT_UNBIASED must be in -7..15");
    end
  endgenerate

  logic       adv1;
  logic       adv2;
  logic       in_fire;

  logic       v1_q, v1_d;
  logic [7:0] d1_q, d1_d;
  logic [3:0] lz1_q, lz1_d;
  logic [3:0] lz_in;

  logic       v2_q, v2_d;
  fp16_t      fp16_q, fp16_d;

  logic [7:0]           mant_shifted;
  logic [EXP_WIDTH-1:0] exp_w;
  fp16_t                packed_w;

  u8_fp16_converter_lzc8 u_lzc8 (
    .data_i  (bus.u8_i),
    .count_o (lz_in)
  );

  // A stage may advance when it is empty or its consumer takes its contents this cycle.
  always_comb begin
    adv2    = !v2_q || bus.ready_i;
    adv1    = !v1_q || adv2;
    in_fire = bus.valid_i && adv1;
  end

  always_comb begin
    v1_d  = v1_q;
    d1_d  = d1_q;
    lz1_d = lz1_q;
    if (adv1) begin
      v1_d = bus.valid_i;
    end
    if (in_fire) begin
      d1_d  = bus.u8_i;
      lz1_d = lz_in;
    end
  end

  // Shifting by lz+1 pushes the leading one out, leaving the 8 bits below it.
  always_comb begin
    mant_shifted = d1_q << (lz1_q + 4'd1);
    exp_w        = EXP_WIDTH'(LEAD_EXPONENT - int'(lz1_q));
    if (d1_q == 8'd0) begin
      packed_w = fp16_pack(1'b0, '0, '0);
    end else begin
      packed_w = fp16_pack(1'b0, exp_w, {mant_shifted, 2'b00});
    end
  end

  always_comb begin
    v2_d   = v2_q;
    fp16_d = fp16_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        fp16_d = packed_w;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      lz1_q  <= '0;
      v2_q   <= 1'b0;
      fp16_q <= '0;
    end else begin
      v1_q   <= v1_d;
      d1_q   <= d1_d;
      lz1_q  <= lz1_d;
      v2_q   <= v2_d;
      fp16_q <= fp16_d;
    end
  end

  assign bus.ready_o = adv1;
  assign bus.valid_o = v2_q;
  assign bus.fp16_o  = fp16_q;

endmodule

// File: tb/tb_u8_fp16_converter.sv
// tb/tb_u8_fp16_converter.sv - directed and randomised-handshake bench for u8_fp16_converter
module tb_u8_fp16_converter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  u8_fp16_converter_if bus7 ();
  u8_fp16_converter_if bus3 ();
  u8_fp16_converter_if busm7 ();
  u8_fp16_converter_if bus15 ();

  u8_fp16_converter #(.LEAD_EXPONENT_UNBIASED(7))  dut7  (.clk_i(clk), .rst_ni(rst_n), .bus(bus7));
  u8_fp16_converter #(.LEAD_EXPONENT_UNBIASED(3))  dut3  (.clk_i(clk), .rst_ni(rst_n), .bus(bus3));
  u8_fp16_converter #(.LEAD_EXPONENT_UNBIASED(-7)) dutm7 (.clk_i(clk), .rst_ni(rst_n), .bus(busm7));
  u8_fp16_converter #(.LEAD_EXPONENT_UNBIASED(15)) dut15 (.clk_i(clk), .rst_ni(rst_n), .bus(bus15));

  task automatic idle_all();
    bus7.u8_i  = 8'd0; bus7.valid_i  = 1'b0; bus7.ready_i  = 1'b1;
    bus3.u8_i  = 8'd0; bus3.valid_i  = 1'b0; bus3.ready_i  = 1'b1;
    busm7.u8_i = 8'd0; busm7.valid_i = 1'b0; busm7.ready_i = 1'b1;
    bus15.u8_i = 8'd0; bus15.valid_i = 1'b0; bus15.ready_i = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: value u * 2**(l-7) as fp16, built from the position of the top set bit.
  function automatic logic [15:0] model_fp16(input int u, input int l);
    int p;
    int f;
    if (u == 0) return 16'h0000;
    p = 0;
    for (int b = 0; b < 8; b++) if (u[b]) p = b;
    f = (u << (10 - p)) & 32'h3ff;
    return {1'b0, 5'(p + l - 7 + 15), 10'(f)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus7.valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_valid_o got=%b exp=0", bus7.valid_o);
    end
    checks++;
    if (bus7.fp16_o !== 16'h0000) begin
      failures++; $display("FAIL reset_fp16_o got=%h exp=0000", bus7.fp16_o);
    end
    checks++;
    if (bus7.ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_ready_o got=%b exp=1", bus7.ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vin  [4];
    logic [15:0] vexp [4];
    vin  = '{8'd1, 8'd128, 8'd255, 8'd0};
    vexp = '{16'h3c00, 16'h5800, 16'h5bf8, 16'h0000};
    bus7.ready_i = 1'b1;
    bus7.u8_i    = vin[0];
    bus7.valid_i = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      next_cycle();
      checks++;
      if (t >= 2 && t <= 5) begin
        if (bus7.valid_o !== 1'b1 || bus7.fp16_o !== vexp[t-2]) begin
          failures++;
          $display("FAIL t1_out%0d got valid=%b data=%h exp valid=1 data=%h", t - 2, bus7.valid_o, bus7.fp16_o, vexp[t-2]);
        end
      end else if (bus7.valid_o !== 1'b0) begin
        failures++; $display("FAIL t1_idle_cycle%0d got valid=%b exp=0", t, bus7.valid_o);
      end
      if (t < 4) bus7.u8_i = vin[t];
      else bus7.valid_i = 1'b0;
    end
  endtask

  task automatic test_binary_point();
    logic [7:0]  vin  [3];
    logic [15:0] vexp [3];
    vin  = '{8'h10, 8'h01, 8'hff};
    vexp = '{16'h3c00, 16'h2c00, 16'h4bf8};
    bus3.u8_i    = vin[0];
    bus3.valid_i = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      next_cycle();
      if (t >= 2 && t <= 4) begin
        checks++;
        if (bus3.valid_o !== 1'b1 || bus3.fp16_o !== vexp[t-2]) begin
          failures++;
          $display("FAIL t2_out%0d got valid=%b data=%h exp valid=1 data=%h", t - 2, bus3.valid_o, bus3.fp16_o, vexp[t-2]);
        end
      end
      if (t < 3) bus3.u8_i = vin[t];
      else bus3.valid_i = 1'b0;
    end
  endtask

  task automatic test_limits();
    logic [15:0] exp_lo [2];
    logic [15:0] exp_hi [2];
    exp_lo = '{16'h0400, 16'h2000};
    exp_hi = '{16'h5c00, 16'h7800};
    busm7.u8_i = 8'd1; busm7.valid_i = 1'b1;
    bus15.u8_i = 8'd1; bus15.valid_i = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      if (t == 2 || t == 3) begin
        checks++;
        if (busm7.valid_o !== 1'b1 || busm7.fp16_o !== exp_lo[t-2]) begin
          failures++;
          $display("FAIL t6_lmin_out%0d got valid=%b data=%h exp=%h", t - 2, busm7.valid_o, busm7.fp16_o, exp_lo[t-2]);
        end
        checks++;
        if (bus15.valid_o !== 1'b1 || bus15.fp16_o !== exp_hi[t-2]) begin
          failures++;
          $display("FAIL t6_lmax_out%0d got valid=%b data=%h exp=%h", t - 2, bus15.valid_o, bus15.fp16_o, exp_hi[t-2]);
        end
      end
      if (t == 1) begin
        busm7.u8_i = 8'd128;
        bus15.u8_i = 8'd128;
      end else begin
        busm7.valid_i = 1'b0;
        bus15.valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_random_stream();
    int          sent = 0;
    int          got = 0;
    int          cycles = 0;
    logic        stalled = 1'b0;
    logic        in_acc;
    logic [15:0] held = 16'h0000;
    bus7.valid_i = 1'b0;
    bus7.ready_i = 1'b1;
    while (got < 256 && cycles < 20000) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (bus7.valid_o !== 1'b1 || bus7.fp16_o !== held) begin
          failures++;
          $display("FAIL t3_stall_hold got valid=%b data=%h exp valid=1 data=%h", bus7.valid_o, bus7.fp16_o, held);
        end
      end
      stalled = bus7.valid_o && !bus7.ready_i;
      held    = bus7.fp16_o;
      if (bus7.valid_o && bus7.ready_i) begin
        checks++;
        if (bus7.fp16_o !== model_fp16(got, 7)) begin
          failures++;
          $display("FAIL t3_out%0d got=%h exp=%h", got, bus7.fp16_o, model_fp16(got, 7));
        end
        got++;
      end
      in_acc = bus7.valid_i && bus7.ready_o;
      if (in_acc) sent++;
      next_cycle();
      cycles++;
      if (!bus7.valid_i || in_acc) begin
        if (sent < 256 && $urandom_range(0, 3) != 0) begin
          bus7.valid_i = 1'b1;
          bus7.u8_i    = sent[7:0];
        end else begin
          bus7.valid_i = 1'b0;
        end
      end
      bus7.ready_i = ($urandom_range(0, 3) != 0);
    end
    bus7.valid_i = 1'b0;
    bus7.ready_i = 1'b1;
    checks++;
    if (got !== 256) begin
      failures++; $display("FAIL t3_count got=%0d exp=256", got);
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_stall();
    bus7.ready_i = 1'b0;
    bus7.u8_i    = 8'd5;
    bus7.valid_i = 1'b1;
    next_cycle();
    bus7.u8_i = 8'd6;
    next_cycle();
    bus7.valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus7.ready_o !== 1'b0 || bus7.valid_o !== 1'b1 || bus7.fp16_o !== 16'h4500) begin
        failures++;
        $display("FAIL t4_full%0d got ready=%b valid=%b data=%h exp ready=0 valid=1 data=4500", k, bus7.ready_o, bus7.valid_o, bus7.fp16_o);
      end
      if (k < 3) next_cycle();
    end
    bus7.ready_i = 1'b1;
    #1;
    checks++;
    if (bus7.ready_o !== 1'b1) begin
      failures++; $display("FAIL t4_ready_passthru got=%b exp=1", bus7.ready_o);
    end
    next_cycle();
    checks++;
    if (bus7.valid_o !== 1'b1 || bus7.fp16_o !== 16'h4600) begin
      failures++; $display("FAIL t4_second got valid=%b data=%h exp valid=1 data=4600", bus7.valid_o, bus7.fp16_o);
    end
    next_cycle();
    checks++;
    if (bus7.valid_o !== 1'b0) begin
      failures++; $display("FAIL t4_no_dup got valid=%b exp=0", bus7.valid_o);
    end
  endtask

  task automatic test_async_reset();
    int first = -1;
    bus7.ready_i = 1'b1;
    bus7.u8_i    = 8'd10;
    bus7.valid_i = 1'b1;
    next_cycle();
    bus7.u8_i = 8'd20;
    next_cycle();
    bus7.u8_i = 8'd30;
    next_cycle();
    bus7.valid_i = 1'b0;
    checks++;
    if (bus7.valid_o !== 1'b1) begin
      failures++; $display("FAIL t5_live got valid=%b exp=1", bus7.valid_o);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus7.valid_o !== 1'b0 || bus7.fp16_o !== 16'h0000) begin
      failures++; $display("FAIL t5_async_clear got valid=%b data=%h exp valid=0 data=0000", bus7.valid_o, bus7.fp16_o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    next_cycle();
    bus7.u8_i    = 8'd40;
    bus7.valid_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 1) bus7.valid_i = 1'b0;
      if (bus7.valid_o === 1'b1 && first < 0) begin
        first = k;
        checks++;
        if (bus7.fp16_o !== 16'h5100) begin
          failures++; $display("FAIL t5_first_out got=%h exp=5100", bus7.fp16_o);
        end
      end
    end
    checks++;
    if (first !== 2) begin
      failures++; $display("FAIL t5_first_latency got=%0d exp=2", first);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_binary_point();
    test_limits();
    test_random_stream();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
